// File: rtl/debounce_pkg.sv
// Shared defaults, channel action encoding and counter-width helper for debounce2.
package debounce_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 4;

    // What a channel does with its counter and stable level at the next edge.
    typedef enum logic [1:0] {
        CH_CLEAR  = 2'd0,  // synchronized level agrees with Q: restart the count
        CH_COUNT  = 2'd1,  // mismatch still too young: keep counting
        CH_ACCEPT = 2'd2   // mismatch persisted DB_CYCLES edges: take the new level
    } ch_action_e;

    // Bits needed to hold 0..db_cycles.
    function automatic int cnt_width(input int db_cycles);
        return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce2_if.sv
// Raw-level inputs and debounced outputs of the two-channel debouncer.
interface debounce2_if;

    logic A_RAW;
    logic B_RAW;
    logic A;
    logic B;
    logic CHG;

    // Environment side: drives raw levels, observes debounced levels.
    modport master (
        output A_RAW,
        output B_RAW,
        input  A,
        input  B,
        input  CHG
    );

    // Debouncer side.
    modport slave (
        input  A_RAW,
        input  B_RAW,
        output A,
        output B,
        output CHG
    );

endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: synchronizer chain, persistence counter, stable level
// and a strobe marking the edge at which the stable level is updated.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic q,
    output logic upd
);

    localparam int               CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    ch_action_e             action;

    // Synchronizer chain: raw enters at bit 0, the synchronized level leaves the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the synchronizer is cleared with everything else, so a level caught
        // in flight when reset hits is dropped and must travel the full chain again.
        if (!rst_n) begin
            sync <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // Decide what the counter and level do at the coming edge.
    always_comb begin
        // NOTE: default first so every path assigns action and no latch is inferred.
        action = CH_CLEAR;
        if (s != q) begin
            action = (cnt == CNT_LAST) ? CH_ACCEPT : CH_COUNT;
        end
    end

    // Persistence counter and stable level; the counter stops at CNT_LAST and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= 1'b0;
        end else begin
            unique case (action)
                CH_COUNT: begin
                    cnt <= cnt + 1'b1;
                end
                CH_ACCEPT: begin
                    cnt <= '0;
                    q   <= s;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // High during the cycle whose closing edge loads a new level into q.
    assign upd = (action == CH_ACCEPT);

endmodule

// File: rtl/debounce2.sv
// Two independent debounce channels feeding a downstream AND stage, plus a
// registered one-cycle change pulse shared by both channels.
module debounce2
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    debounce2_if.slave bus
);

    logic upd_a;
    logic upd_b;

    debounce_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_ch_a (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (bus.A_RAW),
        .q     (bus.A),
        .upd   (upd_a)
    );

    debounce_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_ch_b (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (bus.B_RAW),
        .q     (bus.B),
        .upd   (upd_b)
    );

    // One pulse per updating edge, even when both channels update together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.CHG <= 1'b0;
        end else begin
            bus.CHG <= upd_a | upd_b;
        end
    end

endmodule

// File: tb/tb_debounce2.sv
// Self-checking bench for debounce2: a vector table applied through a scoreboard,
// followed by hand-written sequences for mid-count reset and DB_CYCLES == 1.
module tb_debounce2;

    typedef struct {
        string tag;
        bit    rst;      // reset before this vector; edge numbering restarts at 1
        logic  a_raw;
        logic  b_raw;
        logic  exp_a;
        logic  exp_b;
        logic  exp_chg;
    } vec_t;

    typedef struct {
        string name;
        logic  a;
        logic  b;
        logic  chg;
    } exp_t;

    logic CLK;
    logic RST_N = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];
    exp_t sb[$];
    logic [1:0] combos [8];
    logic and_out;

    debounce2_if bus ();
    debounce2_if bus1 ();

    assign bus1.A_RAW = bus.A_RAW;
    assign bus1.B_RAW = bus.B_RAW;
    assign and_out    = bus.A & bus.B;

    debounce2 dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    debounce2 #(
        .SYNC_STAGES (2),
        .DB_CYCLES   (1)
    ) dut1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic void add(input string tag, input bit rst, input logic a, input logic b,
                                input logic ea, input logic eb, input logic ec);
        vec_t v;
        v = '{tag: tag, rst: rst, a_raw: a, b_raw: b, exp_a: ea, exp_b: eb, exp_chg: ec};
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST_N     = 1'b0;
        bus.A_RAW = 1'b0;
        bus.B_RAW = 1'b0;
        #1;
        check("reset A", bus.A, 1'b0);
        check("reset B", bus.B, 1'b0);
        check("reset CHG", bus.CHG, 1'b0);
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        sb.delete();
    endtask

    // Drive one vector at the falling edge, push its expectation, compare after the next rising edge.
    task automatic step(input vec_t v, input int e);
        exp_t x;
        @(negedge CLK);
        bus.A_RAW = v.a_raw;
        bus.B_RAW = v.b_raw;
        x = '{name: $sformatf("%s@%0d", v.tag, e), a: v.exp_a, b: v.exp_b, chg: v.exp_chg};
        sb.push_back(x);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard %s@%0d: got empty queue, expected one entry", v.tag, e);
        end else begin
            x = sb.pop_front();
            check({x.name, " A"}, bus.A, x.a);
            check({x.name, " B"}, bus.B, x.b);
            check({x.name, " CHG"}, bus.CHG, x.chg);
            check({x.name, " AND"}, and_out, x.a & x.b);
        end
    endtask

    initial begin
        int         edge_n;
        logic [1:0] prev;
        vec_t       v;

        bus.A_RAW = 1'b0;
        bus.B_RAW = 1'b0;
        combos = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10};

        // Idle after reset: nothing moves for 20 cycles.
        for (int e = 1; e <= 20; e++) add("idle", e == 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // A_RAW rises before edge 10: A at edge 15, one CHG pulse, B untouched.
        for (int e = 1; e <= 20; e++) add("rise_a", e == 1, e >= 10, 1'b0, e >= 15, 1'b0, e == 15);
        // 3-cycle glitch rejected; 4-cycle pulse accepted at 18, released at 22.
        for (int e = 1; e <= 24; e++)
            add("glitch", e == 1, (e >= 3 && e <= 5) || (e >= 13 && e <= 16), 1'b0,
                e >= 18 && e <= 21, 1'b0, e == 18 || e == 22);
        // Both rise together: both outputs at edge 15, a single CHG pulse.
        for (int e = 1; e <= 18; e++) add("both", e == 1, e >= 10, e >= 10, e >= 15, e >= 15, e == 15);
        // Sweep of A/B combinations held 8 cycles: outputs lag raw by 5 edges.
        prev = 2'b00;
        for (int e = 1; e <= 69; e++) begin
            logic [1:0] cur;
            logic [1:0] lag;
            cur = combos[(((e > 64) ? 64 : e) - 1) / 8];
            lag = (e > 5) ? combos[(e - 6) / 8] : 2'b00;
            add("sweep", e == 1, cur[1], cur[0], lag[1], lag[0], lag != prev);
            prev = lag;
        end

        edge_n = 0;
        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset();
                edge_n = 0;
            end
            edge_n++;
            step(vecs[i], edge_n);
        end

        // Reset pulsed mid-count: the pending rise is discarded and restarts from edge 13.
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            v = '{tag: "rst_mid", rst: 1'b0, a_raw: e >= 10, b_raw: 1'b0,
                  exp_a: 1'b0, exp_b: 1'b0, exp_chg: 1'b0};
            step(v, e);
        end
        #1;
        RST_N = 1'b0;
        #1;
        check("rst_mid in reset A", bus.A, 1'b0);
        check("rst_mid in reset CHG", bus.CHG, 1'b0);
        #1;
        RST_N = 1'b1;
        for (int e = 13; e <= 20; e++) begin
            v = '{tag: "rst_mid", rst: 1'b0, a_raw: 1'b1, b_raw: 1'b0,
                  exp_a: e >= 18, exp_b: 1'b0, exp_chg: e == 18};
            step(v, e);
        end

        // DB_CYCLES == 1 accepts on the first mismatching edge: capture at 1, output at 3.
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            @(negedge CLK);
            bus.A_RAW = 1'b1;
            bus.B_RAW = 1'b0;
            @(posedge CLK);
            #1;
            check($sformatf("db1@%0d A", e), bus1.A, e >= 3);
            check($sformatf("db1@%0d B", e), bus1.B, 1'b0);
            check($sformatf("db1@%0d CHG", e), bus1.CHG, e == 3);
            check($sformatf("db1@%0d main A", e), bus.A, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/debounce2.md
DEBOUNCE2 -- requirements
Module: debounce2

Interface
REQ-001 Parameter SYNC_STAGES, default 2, meaning: synchronizer flops per channel; legal range 2..4.
REQ-002 Parameter DB_CYCLES, default 4, meaning: consecutive cycles a new synchronized level must persist before acceptance; legal range 1..255.
REQ-003 Port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 Port A_RAW  input  1  asynchronous raw level, channel A.
REQ-006 Port B_RAW  input  1  asynchronous raw level, channel B.
REQ-007 Port A  output  1  debounced registered level A; drives the downstream 2-input AND stage input A.
REQ-008 Port B  output  1  debounced registered level B; drives the downstream AND stage input B.
REQ-009 Port CHG  output  1  single-cycle pulse, high in the cycle after A or B changes.

Function
REQ-010 Each channel shall pass its raw input through a SYNC_STAGES-deep flop chain; the last stage is the synchronized level S.
REQ-011 Each channel shall hold a counter CNT of width ceil(log2(DB_CYCLES+1)) and a stable level Q (driven on A/B).
REQ-012 Per edge: if S == Q then CNT <= 0.
REQ-013 Per edge: if S != Q and CNT < DB_CYCLES-1 then CNT <= CNT+1, Q unchanged.
REQ-014 Per edge: if S != Q and CNT == DB_CYCLES-1 then Q <= S, CNT <= 0.
REQ-015 Latency: a raw level first captured at edge k and held shall appear on the output at edge k+SYNC_STAGES+DB_CYCLES-1 (default: k+5).
REQ-016 A synchronized pulse lasting fewer than DB_CYCLES cycles shall leave Q unchanged and return CNT to 0.
REQ-017 DB_CYCLES == 1 shall accept a new level on the first mismatching edge.
REQ-018 CNT shall never exceed DB_CYCLES-1; no wrap-around is permitted.
REQ-019 CHG shall be 1 for exactly one cycle after any edge at which A or B updated, including when both update at the same edge (one pulse, not two).
REQ-020 Channels shall be fully independent; simultaneous changes on A_RAW and B_RAW shall resolve each per REQ-012..014.
REQ-021 Outputs A, B, CHG shall be driven directly from flops, with no combinational path from A_RAW or B_RAW.

Reset
REQ-022 RST_N low shall immediately clear all synchronizer flops, CNT, A, B and CHG to 0, independent of CLK.
REQ-023 Reset asserted mid-count shall discard the pending transition; after release, a raw 1 requires the full REQ-015 latency again.
REQ-024 Reset deassertion is synchronized externally; the block does not self-synchronize it.

Structure
REQ-025 Package debounce_pkg shall hold the default values of SYNC_STAGES and DB_CYCLES and a function computing the counter width.
REQ-026 Sub-module debounce_ch (one channel: sync chain, CNT, Q, update strobe) shall be instantiated twice; debounce2 shall OR the strobes and register them into CHG.

Verification (SYNC_STAGES=2, DB_CYCLES=4)
REQ-027 Reset release, A_RAW=B_RAW=0 for 20 cycles -> A=B=CHG=0 throughout.
REQ-028 A_RAW 0->1 before edge 10, held -> A=1 from edge 15, CHG=1 only during cycle 15..16, B=0.
REQ-029 A_RAW high for 3 cycles then low -> A stays 0, CHG never asserts; after a subsequent 4-cycle pulse, A=1.
REQ-030 A_RAW and B_RAW rise together before edge 10 -> A and B both 1 at edge 15, exactly one CHG pulse.
REQ-031 A_RAW rises before edge 10; RST_N pulsed low between edges 12 and 13 -> A stays 0, becomes 1 at edge 18 (counting from first edge after release at 13).
REQ-032 Sweep all four A/B combinations with settled holds -> downstream AND output equals A&B, lagging raw inputs by 5 cycles.
